// File: rtl/cpu_fifo_pkg.sv
// -----------------------------------------------------------------------------
// cpu_fifo_pkg
// Shared definitions for the CPU packet FIFO controller: FSM state encoding,
// default buffer address width, control-byte constants and drop counter width.
// -----------------------------------------------------------------------------
package cpu_fifo_pkg;

   // Default packet buffer address width (512 words).
   localparam int ADDR_W_DEF = 9;

   // Control byte marking a module header word; never an end-of-packet marker.
   localparam logic [7:0] CTRL_MODULE_HDR = 8'hFF;

   // Width of the optional dropped-packet counter.
   localparam int DROP_CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,  // waiting for the first word of a packet
      ST_RECV = 3'd1,  // storing packet words into the buffer
      ST_PROC = 3'd2,  // complete packet held, CPU owns the buffer
      ST_SEND = 3'd3,  // streaming the buffer out to the egress port
      ST_DROP = 3'd4   // packet too large, swallowing words until its end
   } state_e;

   // A control byte closes a packet when it is neither data (0) nor a header.
   function automatic logic is_eop_ctrl(input logic [7:0] ctrl);
      return (ctrl != 8'h00) && (ctrl != CTRL_MODULE_HDR);
   endfunction

endpackage

// File: rtl/cpu_fifo_rd_pipe.sv
// -----------------------------------------------------------------------------
// cpu_fifo_rd_pipe
// Buffer read-issue engine for the egress path. Holds the read address,
// issues one read per cycle while enabled and downstream is ready, flags the
// read of the tail word, and delays the issue strobe by one cycle to align
// out_wr with the block RAM's registered read data.
// -----------------------------------------------------------------------------
module cpu_fifo_rd_pipe
   import cpu_fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,       // restart reading from address 0
   input  logic              active_i,      // egress phase in progress
   input  logic              out_rdy_i,     // downstream can take a word
   input  logic [ADDR_W-1:0] tail_addr_i,   // address of the last stored word
   output logic [ADDR_W-1:0] raddr_o,
   output logic              issue_last_o,  // the tail word is being read now
   output logic              out_wr_o
);

   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              out_wr_q, out_wr_d;
   logic              issue;

   // Read issue decision and address advance; the address stops on the tail
   // word so it never wraps past the end of the packet.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      raddr_d      = raddr_q;
      issue        = active_i & out_rdy_i;
      issue_last_o = issue && (raddr_q == tail_addr_i);
      out_wr_d     = issue;
      if (start_i) begin
         raddr_d = '0;
      end else if (issue && !issue_last_o) begin
         raddr_d = raddr_q + ADDR_W'(1);
      end
   end

   // Read address register and one-cycle out_wr delay matching RAM latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         raddr_q  <= '0;
         out_wr_q <= 1'b0;
      end else begin
         raddr_q  <= raddr_d;
         out_wr_q <= out_wr_d;
      end
   end

   assign raddr_o  = raddr_q;
   assign out_wr_o = out_wr_q;

endmodule

// File: rtl/cpu_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_fifo_ctrl
// Packet buffer controller between an upstream word stream, a CPU that
// inspects each stored packet, and a downstream egress port.
//   IDLE -> RECV : first word stored at address 0
//   RECV -> PROC : end-of-packet word stored, tail address latched
//   PROC -> SEND : CPU releases the buffer with a cpu_done pulse
//   SEND -> IDLE : read of the tail word issued
//   RECV -> DROP : packet would need the last buffer address without ending;
//                  remaining words are swallowed until end of packet.
// Build option: define CPU_FIFO_DROP_CNT_EN to add the saturating drop_cnt
// output counting entries into DROP.
// -----------------------------------------------------------------------------
module cpu_fifo_ctrl
   import cpu_fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_wr,
   input  logic [7:0]        in_ctrl,
   output logic              in_rdy,
   input  logic              out_rdy,
   output logic              out_wr,
   input  logic              cpu_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] tail_addr,
   output logic              mux_sel,
   output logic              pkt_ready
`ifdef CPU_FIFO_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;      // address of the last stored word
   logic [ADDR_W-1:0] tail_q, tail_d;
   logic              seen_zero_q, seen_zero_d; // a data word (ctrl 0) was seen

   logic              ctrl_zero;
   logic              eop;
   logic              overflow;
   logic              wr_accept;
   logic              send_start;
   logic [ADDR_W-1:0] wr_addr;
   logic              issue_last;

   // Word classification and the address the current word would be stored at.
   always_comb begin
      ctrl_zero = (in_ctrl == 8'h00);
      eop       = in_wr && seen_zero_q && is_eop_ctrl(in_ctrl);
      wr_addr   = (state_q == ST_IDLE) ? '0 : waddr_q + ADDR_W'(1);
      overflow  = (state_q == ST_RECV) && in_wr && !eop && (wr_addr == ADDR_LAST);
   end

   // FSM state register; reset discards any packet in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (in_wr) state_d = ST_RECV;
         ST_RECV: begin
            if (eop) begin
               state_d = ST_PROC;
            end else if (overflow) begin
               state_d = ST_DROP;
            end
         end
         ST_PROC: if (cpu_done)   state_d = ST_SEND;
         ST_SEND: if (issue_last) state_d = ST_IDLE;
         ST_DROP: if (eop)        state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: handshakes, CPU flags and the write strobe.
   always_comb begin
      in_rdy     = 1'b0;
      pkt_ready  = 1'b0;
      mux_sel    = 1'b0;
      wr_accept  = 1'b0;
      send_start = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_rdy    = 1'b1;
            wr_accept = in_wr;
         end
         ST_RECV: begin
            in_rdy    = 1'b1;
            wr_accept = in_wr && !overflow;
         end
         ST_PROC: begin
            pkt_ready  = 1'b1;
            mux_sel    = 1'b1;
            send_start = cpu_done;
         end
         ST_SEND: begin
            mux_sel = 1'b0;
         end
         ST_DROP: begin
            in_rdy = 1'b1;
         end
         default: begin
            in_rdy = 1'b0;
         end
      endcase
   end

   // Write-side bookkeeping: last stored address, tail latch, data-seen flag.
   always_comb begin
      waddr_d     = waddr_q;
      tail_d      = tail_q;
      seen_zero_d = seen_zero_q;
      if (wr_accept) begin
         waddr_d     = wr_addr;
         seen_zero_d = (state_q == ST_IDLE) ? ctrl_zero : (seen_zero_q | ctrl_zero);
         if ((state_q == ST_RECV) && eop) begin
            tail_d = wr_addr;
         end
      end else if ((state_q == ST_DROP) && in_wr) begin
         seen_zero_d = seen_zero_q | ctrl_zero;
      end
   end

   // Write-side registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         waddr_q     <= '0;
         tail_q      <= '0;
         seen_zero_q <= 1'b0;
      end else begin
         waddr_q     <= waddr_d;
         tail_q      <= tail_d;
         seen_zero_q <= seen_zero_d;
      end
   end

   // The strobe is combinational with the word, so hold it off while reset is
   // asserted even if upstream still drives in_wr.
   assign mem_we    = wr_accept & ~reset;
   assign mem_waddr = ((state_q == ST_IDLE) || (state_q == ST_RECV)) ? wr_addr : waddr_q;
   assign tail_addr = tail_q;

   cpu_fifo_rd_pipe #(
      .ADDR_W (ADDR_W)
   ) u_rd_pipe (
      .clk          (clk),
      .reset        (reset),
      .start_i      (send_start),
      .active_i     (state_q == ST_SEND),
      .out_rdy_i    (out_rdy),
      .tail_addr_i  (tail_q),
      .raddr_o      (mem_raddr),
      .issue_last_o (issue_last),
      .out_wr_o     (out_wr)
   );

`ifdef CPU_FIFO_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_q;
   logic                  drop_entry;

   assign drop_entry = (state_q != ST_DROP) && (state_d == ST_DROP);

   // Saturating count of packets dropped for overflowing the buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt_q <= '0;
      end else if (drop_entry && (drop_cnt_q != '1)) begin
         drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_fifo_ctrl
// Scoreboard bench for cpu_fifo_ctrl. Stimulus pushes expected write
// addresses and expected egress data tokens; a monitor on the falling edge
// pops and compares on every mem_we and out_wr. A behavioural 1-cycle BRAM
// carries a per-word token so egress order and duplication are visible.
// Define CPU_FIFO_DROP_CNT_EN to also exercise drop_cnt.
// -----------------------------------------------------------------------------
module tb_cpu_fifo_ctrl;
   import cpu_fifo_pkg::*;

   localparam int ADDR_W = 9;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_wr;
   logic [7:0]        in_ctrl;
   logic              in_rdy;
   logic              out_rdy;
   logic              out_wr;
   logic              cpu_done;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [ADDR_W-1:0] mem_raddr;
   logic [ADDR_W-1:0] tail_addr;
   logic              mux_sel;
   logic              pkt_ready;
`ifdef CPU_FIFO_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt;
`endif

   logic [15:0] tb_word;
   logic [15:0] bram [0:(1<<ADDR_W)-1];
   logic [15:0] rd_data;

   int total = 0;
   int bad   = 0;
   int out_pulses = 0;
   int pulse_base = 0;
   int pkt_seen   = 0;

   logic [ADDR_W-1:0] exp_wr_q[$];
   logic [15:0]       exp_out_q[$];

   always #5 clk = ~clk;

   cpu_fifo_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_wr     (in_wr),
      .in_ctrl   (in_ctrl),
      .in_rdy    (in_rdy),
      .out_rdy   (out_rdy),
      .out_wr    (out_wr),
      .cpu_done  (cpu_done),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_raddr (mem_raddr),
      .tail_addr (tail_addr),
      .mux_sel   (mux_sel),
      .pkt_ready (pkt_ready)
`ifdef CPU_FIFO_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packet buffer with one-cycle registered read, as seen by the controller.
   always @(posedge clk) begin
      if (mem_we) bram[mem_waddr] <= tb_word;
      rd_data <= bram[mem_raddr];
   end

   // Scoreboard monitor: compare every write and every egress word.
   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_wr_q.size() == 0) check("wr_unexpected", 32'(mem_we), 32'd0);
         else                      check("wr_addr", 32'(mem_waddr), 32'(exp_wr_q.pop_front()));
      end
      if (out_wr) begin
         out_pulses++;
         if (exp_out_q.size() == 0) check("rd_unexpected", 32'(out_wr), 32'd0);
         else                       check("rd_data", 32'(rd_data), 32'(exp_out_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] ctrl, input logic [15:0] tok,
                            input bit wr_exp, input int addr);
      in_wr   = 1'b1;
      in_ctrl = ctrl;
      tb_word = tok;
      if (wr_exp) exp_wr_q.push_back(ADDR_W'(addr));
      tick();
      in_wr   = 1'b0;
      in_ctrl = 8'h00;
   endtask

   task automatic send_pkt4(input logic [15:0] base);
      send_word(8'hFF, base + 16'd0, 1'b1, 0);
      send_word(8'h00, base + 16'd1, 1'b1, 1);
      send_word(8'h00, base + 16'd2, 1'b1, 2);
      send_word(8'h04, base + 16'd3, 1'b1, 3);
   endtask

   // Release a held 4-word packet with downstream always ready and check
   // the read address / out_wr timing relative to SEND entry.
   task automatic readout4(input logic [15:0] base);
      for (int i = 0; i < 4; i++) exp_out_q.push_back(base + 16'(i));
      out_rdy  = 1'b1;
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("send_raddr", 32'(mem_raddr), 32'(k));
         check("send_out_wr", 32'(out_wr), (k >= 1) ? 32'd1 : 32'd0);
         check("send_mux_sel", 32'(mux_sel), 32'd0);
         tick();
      end
      check("send_last_out_wr", 32'(out_wr), 32'd1);
      check("send_back_idle", 32'(in_rdy), 32'd1);
      tick();
      check("send_out_wr_end", 32'(out_wr), 32'd0);
      out_rdy = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_wr = 1'b0; in_ctrl = 8'h00; out_rdy = 1'b0;
      cpu_done = 1'b0; tb_word = 16'h0000;
      #12;
      check("rst_in_rdy",    32'(in_rdy),    32'd1);
      check("rst_out_wr",    32'(out_wr),    32'd0);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_pkt_ready", 32'(pkt_ready), 32'd0);
      check("rst_mux_sel",   32'(mux_sel),   32'd0);
      check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
      check("rst_mem_raddr", 32'(mem_raddr), 32'd0);
      check("rst_tail_addr", 32'(tail_addr), 32'd0);
`ifdef CPU_FIFO_DROP_CNT_EN
      check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      tick();

      // 4-word packet FF,00,00,04 stored at 0..3 and held for the CPU.
      send_pkt4(16'h0100);
      check("p1_tail_addr", 32'(tail_addr), 32'd3);
      check("p1_pkt_ready", 32'(pkt_ready), 32'd1);
      check("p1_mux_sel",   32'(mux_sel),   32'd1);
      check("p1_in_rdy",    32'(in_rdy),    32'd0);

      // Upstream words while the CPU owns the buffer are ignored.
      in_wr = 1'b1; in_ctrl = 8'h04; tb_word = 16'hDEAD;
      repeat (3) tick();
      in_wr = 1'b0; in_ctrl = 8'h00;
      check("proc_hold_pkt_ready", 32'(pkt_ready), 32'd1);
      check("proc_hold_tail",      32'(tail_addr), 32'd3);

      readout4(16'h0100);

      // cpu_done outside PROC does nothing.
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      tick();
      check("idle_done_in_rdy",    32'(in_rdy),    32'd1);
      check("idle_done_pkt_ready", 32'(pkt_ready), 32'd0);
      check("idle_done_mux_sel",   32'(mux_sel),   32'd0);

      // Egress with downstream readiness toggling 1,0,1,0...
      send_pkt4(16'h0200);
      for (int i = 0; i < 4; i++) exp_out_q.push_back(16'h0200 + 16'(i));
      pulse_base = out_pulses;
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         out_rdy = (i % 2 == 0);
         tick();
      end
      out_rdy = 1'b0;
      tick();
      check("stall_pulses",    32'(out_pulses - pulse_base), 32'd4);
      check("stall_queue_empty", 32'(exp_out_q.size()), 32'd0);
      check("stall_idle_in_rdy", 32'(in_rdy), 32'd1);

      // 600-word packet: addresses 0..510 stored, word 511 triggers DROP.
      pkt_seen = 0;
      for (int w = 0; w < 600; w++) begin
         send_word((w == 0) ? 8'hFF : ((w == 599) ? 8'h04 : 8'h00),
                   16'h3000 + 16'(w), (w < 511), w);
         if (pkt_ready) pkt_seen = 1;
         if (w == 520) check("drop_in_rdy", 32'(in_rdy), 32'd1);
      end
      check("drop_pkt_seen",  32'(pkt_seen),  32'd0);
      check("drop_pkt_ready", 32'(pkt_ready), 32'd0);
      check("drop_end_in_rdy", 32'(in_rdy),   32'd1);
`ifdef CPU_FIFO_DROP_CNT_EN
      check("drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      // Next packet lands at address 0 again.
      send_pkt4(16'h0300);
      check("after_drop_tail",  32'(tail_addr), 32'd3);
      check("after_drop_ready", 32'(pkt_ready), 32'd1);
      readout4(16'h0300);

      // Reset in the middle of receiving word 2 of a packet.
      send_word(8'hFF, 16'h0500, 1'b1, 0);
      send_word(8'h00, 16'h0501, 1'b1, 1);
      in_wr = 1'b1; in_ctrl = 8'h00; tb_word = 16'h0502;
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_in_rdy",    32'(in_rdy),    32'd1);
      check("mid_rst_mem_we",    32'(mem_we),    32'd0);
      check("mid_rst_mem_waddr", 32'(mem_waddr), 32'd0);
      check("mid_rst_mem_raddr", 32'(mem_raddr), 32'd0);
      check("mid_rst_tail_addr", 32'(tail_addr), 32'd0);
      check("mid_rst_pkt_ready", 32'(pkt_ready), 32'd0);
      check("mid_rst_mux_sel",   32'(mux_sel),   32'd0);
      check("mid_rst_out_wr",    32'(out_wr),    32'd0);
      in_wr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      tick();
      send_pkt4(16'h0400);
      check("post_rst_tail",  32'(tail_addr), 32'd3);
      check("post_rst_ready", 32'(pkt_ready), 32'd1);
      readout4(16'h0400);

      tick();
      check("end_wr_queue_empty",  32'(exp_wr_q.size()),  32'd0);
      check("end_out_queue_empty", 32'(exp_out_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
